dft_scan_ctrl: RTL and testbench
================================

// Module: dft_scan_ctrl
// PURPOSE
// Control stage directly upstream of dft_datapath; it drives that block's sc_sen/buf_* controls and consumes dft_out.
// Accepts host commands over val/rdy: SCAN shifts N bits of the DUT scan chain into the SIPO buffer; READ pulls one 32-bit word.
// Returns one response per command with data or error status. Guards every buffer handshake with a timeout.
// PARAMETERS
// BUF_BITS     2048  SIPO buffer capacity in bits (256 B)
// CNT_W        12    shift-counter width; must hold BUF_BITS
// ACK_TIMEOUT  255   max cycles waiting for buf_op_ack or buf_op_commit before error
// PORTS
// clk            in   1      clock
// reset          in   1      synchronous, active-high reset
// cmd_val        in   1      command valid
// cmd_rdy        out  1      command ready (high only in IDLE)
// cmd_op         in   1      0=SCAN, 1=READ
// cmd_nbits      in   CNT_W  SCAN bit count; 0 = BUF_BITS
// resp_val       out  1      response valid
// resp_rdy       in   1      response ready
// resp_data      out  32     READ word; 0 for SCAN
// resp_err       out  1      1 = timeout or overflow
// sc_sen         out  1      DUT scan-enable, one bit shifted per high cycle
// buf_sin_sel    out  1      1 routes dft_sin into buffer, 0 forces 0
// buf_op         out  1      buffer op code: 0=SHIFT, 1=READ
// buf_val_op     out  1      one-cycle op-valid strobe
// buf_op_ack     in   1      buffer accepted op
// buf_op_commit  in   1      READ word latched into output register
// buf_scaning    in   1      buffer shifting
// dft_out        in   32     registered buffer word
// BEHAVIOUR
// - Reset: state=IDLE; cmd_rdy=1; resp_val=0; resp_data=0; resp_err=0; sc_sen=0; buf_sin_sel=0; buf_op=0; buf_val_op=0; counters=0.
// - Reset mid-command aborts it; no response is issued. Buffer contents are the datapath's concern.
// - States: IDLE, SREQ, SHIFT, RREQ, RWAIT, RCAP, RESP.
// - IDLE: on cmd_val&cmd_rdy, latch op/nbits; nbits 0 maps to BUF_BITS.
//   SCAN with accumulated fill+nbits > BUF_BITS goes to RESP with err=1 and no shift.
//   Otherwise SCAN->SREQ, READ->RREQ.
// - SREQ: buf_op=0, buf_val_op=1, buf_sin_sel=1; hold the strobe until buf_op_ack, then SHIFT.
// - SHIFT: sc_sen=1 and buf_sin_sel=1 for exactly N consecutive cycles (down-counter), then RESP err=0. fill += N.
//   buf_scaning is not required for completion; bit count comes from the counter.
// - RREQ: buf_op=1, buf_val_op=1 until buf_op_ack, then RWAIT.
// - RWAIT: wait for buf_op_commit, then RCAP. dft_out is valid the cycle after commit.
// - RCAP: resp_data<=dft_out; fill -= min(32, fill); go to RESP.
// - Timeout: in SREQ/RREQ/RWAIT, a wait counter is cleared on state entry.
//   Reaching ACK_TIMEOUT goes to RESP with err=1 and resp_data=0; buf_val_op drops the same cycle.
// - RESP: resp_val=1 with stable data/err until resp_rdy, then IDLE. Handshake in the same cycle as entry is allowed.
// - buf_val_op is never high outside SREQ/RREQ. sc_sen is never high outside SHIFT. cmd_rdy=0 in all non-IDLE states.
// - READ with fill=0 is still issued; buffer returns 0 padding and err=0.
// - All outputs are registered; 1-cycle latency from state entry.
// TESTING
// 1 reset then SCAN nbits=8, ack after 2 cycles -> sc_sen high exactly 8 cycles; resp_val, err=0, data=0.
// 2 SCAN 32 of pattern 0xA5A5A5A5, READ -> resp_data=0xA5A5A5A5 one cycle after commit+capture; err=0.
// 3 SCAN nbits=0 then SCAN 1 -> first shifts 2048 cycles; second gives err=1, no sc_sen pulse.
// 4 READ with buf_op_ack held low -> err=1 after 255 wait cycles; buf_val_op low afterwards; cmd_rdy returns.
// 5 resp_rdy held low 10 cycles -> resp_val/data stable, cmd_rdy=0; cmd_val ignored until handshake.
// 6 reset asserted mid-SHIFT (bit 5 of 16) -> next cycle sc_sen=0, IDLE, no response; new SCAN accepted.

Source files
------------

// File: rtl/dft_scan_ctrl.sv
// dft_scan_ctrl
// Command front end for the scan-capture datapath. A host issues SCAN
// (shift N bits of the DUT scan chain into the SIPO buffer) or READ (pull
// one 32-bit word out of the buffer) over a val/rdy pair. Each command gets
// exactly one response carrying data or an error flag. Every buffer
// handshake is bounded by a timeout.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cmd_val/cmd_rdy            command handshake (cmd_rdy high only in IDLE)
//   cmd_op, cmd_nbits          0=SCAN / 1=READ, SCAN length (0 = BUF_BITS)
//   resp_val/resp_rdy          response handshake
//   resp_data, resp_err        READ word (0 for SCAN), timeout/overflow flag
//   sc_sen                     DUT scan enable, one bit per high cycle
//   buf_sin_sel                route scan-in into the buffer
//   buf_op, buf_val_op         buffer op code (0=SHIFT, 1=READ) and strobe
//   buf_op_ack, buf_op_commit  buffer accepted op / READ word latched
//   buf_scaning                buffer busy shifting (informational)
//   dft_out                    registered buffer word
//
// state | meaning
// IDLE  | waiting for a command
// SREQ  | SHIFT op strobed to buffer, waiting for ack
// SHIFT | scan enable high, counting down N bits
// RREQ  | READ op strobed to buffer, waiting for ack
// RWAIT | waiting for buffer to commit the READ word
// RCAP  | dft_out valid, capture it
// RESP  | response presented until resp_rdy
module dft_scan_ctrl #(
  parameter int BUF_BITS    = 2048,
  parameter int CNT_W       = 12,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  input  logic             cmd_op,
  input  logic [CNT_W-1:0] cmd_nbits,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [31:0]      resp_data,
  output logic             resp_err,
  output logic             sc_sen,
  output logic             buf_sin_sel,
  output logic             buf_op,
  output logic             buf_val_op,
  input  logic             buf_op_ack,
  input  logic             buf_op_commit,
  input  logic             buf_scaning,
  input  logic [31:0]      dft_out
);

  localparam int WT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SREQ, SHIFT, RREQ, RWAIT, RCAP, RESP} state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] len_q, len_nxt;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_nxt;
  logic [CNT_W-1:0] fill_q, fill_nxt;
  logic [WT_W-1:0]  wait_cnt_q, wait_cnt_nxt;
  logic [31:0]      data_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] nbits_eff;
  logic [CNT_W:0]   fill_sum;

  // Completion is defined purely by the shift counter; the buffer's busy
  // flag carries no information this block needs.
  logic unused_scaning;
  assign unused_scaning = buf_scaning;

  assign nbits_eff = (cmd_nbits == '0) ? CNT_W'(BUF_BITS) : cmd_nbits;
  assign fill_sum  = {1'b0, fill_q} + {1'b0, nbits_eff};

  always_comb begin
    state_nxt    = state_q;
    len_nxt      = len_q;
    bit_cnt_nxt  = bit_cnt_q;
    fill_nxt     = fill_q;
    wait_cnt_nxt = wait_cnt_q;
    data_nxt     = resp_data;
    err_nxt      = resp_err;
    case (state_q)
      IDLE: begin
        if (cmd_val && cmd_rdy) begin
          wait_cnt_nxt = WT_W'(ACK_TIMEOUT);
          if (cmd_op) begin
            state_nxt = RREQ;
          end else if (fill_sum > (CNT_W+1)'(BUF_BITS)) begin
            state_nxt = RESP;
            data_nxt  = '0;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = SREQ;
            len_nxt   = nbits_eff;
          end
        end
      end
      SREQ, RREQ, RWAIT: begin
        if ((state_q == RWAIT) ? buf_op_commit : buf_op_ack) begin
          wait_cnt_nxt = WT_W'(ACK_TIMEOUT);
          bit_cnt_nxt  = len_q;
          state_nxt    = (state_q == SREQ) ? SHIFT :
                         (state_q == RREQ) ? RWAIT : RCAP;
        end else if (wait_cnt_q == WT_W'(1)) begin
          state_nxt = RESP;
          data_nxt  = '0;
          err_nxt   = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt_q - WT_W'(1);
        end
      end
      SHIFT: begin
        if (bit_cnt_q == CNT_W'(1)) begin
          state_nxt = RESP;
          fill_nxt  = fill_q + len_q;
          data_nxt  = '0;
          err_nxt   = 1'b0;
        end else begin
          bit_cnt_nxt = bit_cnt_q - CNT_W'(1);
        end
      end
      RCAP: begin
        state_nxt = RESP;
        data_nxt  = dft_out;
        err_nxt   = 1'b0;
        fill_nxt  = (fill_q >= CNT_W'(32)) ? fill_q - CNT_W'(32) : '0;
      end
      RESP: begin
        if (resp_rdy) begin
          state_nxt = IDLE;
          data_nxt  = '0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register and never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      bit_cnt_q   <= '0;
      fill_q      <= '0;
      wait_cnt_q  <= '0;
      cmd_rdy     <= 1'b1;
      resp_val    <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      sc_sen      <= 1'b0;
      buf_sin_sel <= 1'b0;
      buf_op      <= 1'b0;
      buf_val_op  <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      len_q       <= len_nxt;
      bit_cnt_q   <= bit_cnt_nxt;
      fill_q      <= fill_nxt;
      wait_cnt_q  <= wait_cnt_nxt;
      cmd_rdy     <= (state_nxt == IDLE);
      resp_val    <= (state_nxt == RESP);
      resp_data   <= data_nxt;
      resp_err    <= err_nxt;
      sc_sen      <= (state_nxt == SHIFT);
      buf_sin_sel <= (state_nxt == SREQ) || (state_nxt == SHIFT);
      buf_op      <= (state_nxt == RREQ);
      buf_val_op  <= (state_nxt == SREQ) || (state_nxt == RREQ);
    end
  end

endmodule

// File: tb/tb_dft_scan_ctrl.sv
module tb_dft_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_val, cmd_op;
  logic [11:0] cmd_nbits;
  logic        cmd_rdy, resp_val, resp_rdy, resp_err;
  logic [31:0] resp_data, dft_out;
  logic        sc_sen, buf_sin_sel, buf_op, buf_val_op;
  logic        buf_op_ack, buf_op_commit, buf_scaning;

  int total = 0;
  int bad   = 0;

  int sen_cnt = 0;
  int bvo_cnt = 0;
  int rv_cnt  = 0;

  logic [31:0] pat;
  logic [31:0] sreg = '0;
  logic [4:0]  sidx = '0;

  dft_scan_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_nbits(cmd_nbits),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data), .resp_err(resp_err),
    .sc_sen(sc_sen), .buf_sin_sel(buf_sin_sel), .buf_op(buf_op), .buf_val_op(buf_val_op),
    .buf_op_ack(buf_op_ack), .buf_op_commit(buf_op_commit), .buf_scaning(buf_scaning),
    .dft_out(dft_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sc_sen)     sen_cnt <= sen_cnt + 1;
    if (buf_val_op) bvo_cnt <= bvo_cnt + 1;
    if (resp_val)   rv_cnt  <= rv_cnt + 1;
  end

  // Scan chain feeding the SIPO buffer, MSB of the pattern first.
  always @(posedge clk) begin
    if (sc_sen && buf_sin_sel) begin
      sreg <= {sreg[30:0], pat[~sidx]};
      sidx <= sidx + 5'd1;
    end
  end

  assign buf_scaning = sc_sen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic op, input logic [11:0] nbits);
    int n = 0;
    cmd_val = 1'b1; cmd_op = op; cmd_nbits = nbits;
    while (!cmd_rdy && n < 20) begin tick(); n++; end
    chk("cmd_rdy_wait", cmd_rdy, 1);
    tick();
    cmd_val = 1'b0;
  endtask

  task automatic ack_op(input logic exp_op, input int delay);
    int n = 0;
    while (!buf_val_op && n < 20) begin tick(); n++; end
    chk("val_op_wait", buf_val_op, 1);
    chk("buf_op", buf_op, exp_op);
    chk("sin_sel", buf_sin_sel, !exp_op);
    repeat (delay) tick();
    buf_op_ack = 1'b1;
    tick();
    buf_op_ack = 1'b0;
  endtask

  task automatic commit_word(input logic [31:0] word);
    tick();
    buf_op_commit = 1'b1;
    tick();
    buf_op_commit = 1'b0;
    dft_out = word;
    tick();
    dft_out = 32'hDEAD_BEEF;
  endtask

  task automatic wait_resp(input int max);
    int n = 0;
    while (!resp_val && n < max) begin tick(); n++; end
    chk("resp_wait", resp_val, 1);
  endtask

  task automatic handshake();
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    chk("cmd_rdy_back", cmd_rdy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int s0, b0, r0, n;
    pat = 32'hA5A5_A5A5;
    reset = 1'b1; cmd_val = 1'b0; cmd_op = 1'b0; cmd_nbits = '0;
    resp_rdy = 1'b0; buf_op_ack = 1'b0; buf_op_commit = 1'b0;
    dft_out = 32'hDEAD_BEEF;
    repeat (3) tick();

    // reset state
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_resp_val", resp_val, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_sc_sen", sc_sen, 0);
    chk("rst_sin_sel", buf_sin_sel, 0);
    chk("rst_buf_op", buf_op, 0);
    chk("rst_val_op", buf_val_op, 0);
    reset = 1'b0;
    tick();

    // 1: SCAN 8, ack after 2 cycles
    s0 = sen_cnt;
    send_cmd(1'b0, 12'd8);
    chk("t1_sen_pre", sen_cnt - s0, 0);
    ack_op(1'b0, 2);
    wait_resp(40);
    chk("t1_sen_cnt", sen_cnt - s0, 8);
    chk("t1_err", resp_err, 0);
    chk("t1_data", resp_data, 0);
    chk("t1_sen_off", sc_sen, 0);
    handshake();

    // 2: SCAN 32 of A5A5A5A5 then READ it back
    send_cmd(1'b0, 12'd32);
    ack_op(1'b0, 0);
    wait_resp(60);
    chk("t2_scan_err", resp_err, 0);
    handshake();
    send_cmd(1'b1, 12'd0);
    ack_op(1'b1, 1);
    commit_word(sreg);
    wait_resp(10);
    chk("t2_data", resp_data, 32'hA5A5_A5A5);
    chk("t2_err", resp_err, 0);
    handshake();

    // 3: SCAN 0 fills 2048 bits, then SCAN 1 overflows
    reset = 1'b1; tick(); reset = 1'b0; tick();
    s0 = sen_cnt;
    send_cmd(1'b0, 12'd0);
    ack_op(1'b0, 0);
    wait_resp(2100);
    chk("t3_full_sen", sen_cnt - s0, 2048);
    chk("t3_full_err", resp_err, 0);
    handshake();
    s0 = sen_cnt; b0 = bvo_cnt;
    send_cmd(1'b0, 12'd1);
    wait_resp(10);
    chk("t3_ovf_err", resp_err, 1);
    chk("t3_ovf_data", resp_data, 0);
    chk("t3_ovf_sen", sen_cnt - s0, 0);
    chk("t3_ovf_req", bvo_cnt - b0, 0);
    handshake();

    // 4: READ with no ack times out after 255 cycles
    b0 = bvo_cnt;
    send_cmd(1'b1, 12'd0);
    wait_resp(300);
    chk("t4_err", resp_err, 1);
    chk("t4_data", resp_data, 0);
    chk("t4_val_op_cycles", bvo_cnt - b0, 255);
    chk("t4_val_op_low", buf_val_op, 0);
    handshake();
    chk("t4_val_op_after", buf_val_op, 0);

    // 5: response back-pressure, commands ignored meanwhile
    send_cmd(1'b1, 12'd0);
    ack_op(1'b1, 0);
    commit_word(32'h1234_5678);
    wait_resp(10);
    b0 = bvo_cnt; s0 = sen_cnt;
    cmd_val = 1'b1; cmd_op = 1'b0; cmd_nbits = 12'd4;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_val", resp_val, 1);
      chk("t5_data", resp_data, 32'h1234_5678);
      chk("t5_cmd_rdy", cmd_rdy, 0);
    end
    cmd_val = 1'b0;
    handshake();
    repeat (4) tick();
    chk("t5_no_req", bvo_cnt - b0, 0);
    chk("t5_no_sen", sen_cnt - s0, 0);

    // 6: reset in the middle of a 16-bit SHIFT
    s0 = sen_cnt;
    send_cmd(1'b0, 12'd16);
    ack_op(1'b0, 0);
    n = 0;
    while ((sen_cnt - s0) < 5 && n < 40) begin tick(); n++; end
    chk("t6_reach_bit5", sen_cnt - s0, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_sen_off", sc_sen, 0);
    chk("t6_cmd_rdy", cmd_rdy, 1);
    chk("t6_no_resp", resp_val, 0);
    r0 = rv_cnt;
    repeat (5) tick();
    chk("t6_no_resp_later", rv_cnt - r0, 0);
    s0 = sen_cnt;
    send_cmd(1'b0, 12'd4);
    ack_op(1'b0, 1);
    wait_resp(20);
    chk("t6_new_sen", sen_cnt - s0, 4);
    chk("t6_new_err", resp_err, 0);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
